led_pattern_gen: RTL and testbench

- Parametrised LED driver for the Alchitry Cu LED bank. It generalises fixed per-LED constant assignments into a timed pattern engine.
- Holds a loadable pattern register.
- A clock prescaler generates step ticks.
- Drives N_LEDS outputs in one of four modes: static, blink, rotate, bounce.
- Sits between top-level switch/control logic and the LED pins.

---
 rtl/led_pattern_gen_if.sv | 39 +++
 rtl/led_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// led_pattern_gen_if
// Control / display bundle between the board-level switch logic and the LED
// pattern engine.
//
//   mode     control -> engine  0=static, 1=blink, 2=rotate-left, 3=bounce
//   pattern  control -> engine  value captured when load is high
//   load     control -> engine  single-cycle capture strobe
//   led      engine  -> control LED drive, bit i is LED i, 1 = on
//   step     engine  -> control one-cycle pulse on every step tick
//
// master: the controlling side (drives mode/pattern/load).
// slave : the pattern engine itself.
// -----------------------------------------------------------------------------
interface led_pattern_gen_if #(
   parameter int N_LEDS = 8
);
   logic [1:0]        mode;
   logic [N_LEDS-1:0] pattern;
   logic              load;
   logic [N_LEDS-1:0] led;
   logic              step;

   modport master (
      output mode,
      output pattern,
      output load,
      input  led,
      input  step
   );

   modport slave (
      input  mode,
      input  pattern,
      input  load,
      output led,
      output step
   );
endinterface : led_pattern_gen_if

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Timed LED pattern engine. A prescaler produces a step tick every TICK_DIV
// clocks; on each tick the blink phase toggles, the working pattern rotates
// left by one and the bounce position walks 0..N-1..0. The LED bank shows one
// of four views of that state, selected by the registered mode.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bus (slave)  mode / pattern / load in, led / step out
//
// A load strobe or any change of mode restarts the engine (prescaler, phase,
// rotation and bounce) from a known start, and that restart wins over a tick
// landing in the same cycle.
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int                N_LEDS        = 8,
   parameter int                TICK_DIV      = 12_500_000,
   parameter logic [N_LEDS-1:0] RESET_PATTERN = N_LEDS'(8'hBB)
) (
   input logic              clk,
   input logic              rst_n,
   led_pattern_gen_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LEDS - 2);

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_ROTATE = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;

   // Bounce direction is the only true state machine in the engine.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Registered state and its next-state values.
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              step_q,  step_d;
   logic [1:0]        mode_q,  mode_d;
   logic [N_LEDS-1:0] pat_q,   pat_d;
   logic [N_LEDS-1:0] work_q,  work_d;
   logic              phase_q, phase_d;
   logic [POS_W-1:0]  pos_q,   pos_d;
   dir_e              dir_q,   dir_d;

   logic              tick_s;
   logic              init_s;
   logic [N_LEDS-1:0] led_s;

   // Prescaler terminal count and restart request.
   always_comb begin
      tick_s = (cnt_q == CNT_LAST);
      init_s = bus.load || (bus.mode != mode_q);
   end

   // Next-state logic: restart has priority, otherwise advance on a tick.
   always_comb begin
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      mode_d  = bus.mode;
      pat_d   = pat_q;
      work_d  = work_q;
      phase_d = phase_q;
      pos_d   = pos_q;
      dir_d   = dir_q;

      if (init_s) begin
         // The tick that would have fired this cycle is discarded.
         cnt_d   = {CNT_W{1'b0}};
         step_d  = 1'b0;
         phase_d = 1'b1;
         pos_d   = {POS_W{1'b0}};
         dir_d   = DIR_UP;
         if (bus.load) begin
            pat_d  = bus.pattern;
            work_d = bus.pattern;
         end else begin
            pat_d  = pat_q;
            work_d = pat_q;
         end
      end else if (tick_s) begin
         cnt_d   = {CNT_W{1'b0}};
         step_d  = 1'b1;
         phase_d = ~phase_q;
         work_d  = {work_q[N_LEDS-2:0], work_q[N_LEDS-1]};
         // Turn around at the ends so each end LED is lit for one tick only.
         if ((dir_q == DIR_UP) && (pos_q == POS_LAST)) begin
            dir_d = DIR_DOWN;
            pos_d = POS_PREV;
         end else if ((dir_q == DIR_DOWN) && (pos_q == {POS_W{1'b0}})) begin
            dir_d = DIR_UP;
            pos_d = POS_W'(1);
         end else if (dir_q == DIR_UP) begin
            dir_d = dir_q;
            pos_d = pos_q + POS_W'(1);
         end else begin
            dir_d = dir_q;
            pos_d = pos_q - POS_W'(1);
         end
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
         step_d = 1'b0;
      end
   end

   // State register; reset loads the power-up pattern and start position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= {CNT_W{1'b0}};
         step_q  <= 1'b0;
         mode_q  <= MODE_STATIC;
         pat_q   <= RESET_PATTERN;
         work_q  <= RESET_PATTERN;
         phase_q <= 1'b1;
         pos_q   <= {POS_W{1'b0}};
         dir_q   <= DIR_UP;
      end else begin
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         work_q  <= work_d;
         phase_q <= phase_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
      end
   end

   // Display mux over registered state only, so it adds no latency.
   always_comb begin
      led_s = pat_q;
      case (mode_q)
         MODE_STATIC: led_s = pat_q;
         MODE_BLINK: begin
            if (phase_q) begin
               led_s = pat_q;
            end else begin
               led_s = {N_LEDS{1'b0}};
            end
         end
         MODE_ROTATE: led_s = work_q;
         MODE_BOUNCE: led_s = N_LEDS'(1) << pos_q;
         default:     led_s = pat_q;
      endcase
   end

   assign bus.led  = led_s;
   assign bus.step = step_q;

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen with TICK_DIV=4, N_LEDS=8. A table of
// {mode, pattern, load, expected led, expected step} records is applied one
// clock per record; reset corner cases are driven by hand around it.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   localparam int N   = 8;
   localparam int DIV = 4;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] pattern;
      logic       load;
      logic [7:0] exp_led;
      logic       exp_step;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
   vec_t vecs[$];

   logic [7:0] rot_seq [0:8];
   logic [7:0] bnc_seq [0:15];

   led_pattern_gen_if #(.N_LEDS(N)) bus ();

   led_pattern_gen #(
      .N_LEDS        (N),
      .TICK_DIV      (DIV),
      .RESET_PATTERN (8'hBB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] m, input logic [7:0] p, input logic ld,
                      input logic [7:0] el, input logic es);
      vec_t v;
      v.mode = m; v.pattern = p; v.load = ld; v.exp_led = el; v.exp_step = es;
      vecs.push_back(v);
   endtask

   // Entered just after a falling edge; drives, clocks, checks, returns at the next falling edge.
   task automatic apply(input vec_t v, input int idx);
      bus.mode    = v.mode;
      bus.pattern = v.pattern;
      bus.load    = v.load;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.led", idx), bus.led, v.exp_led);
      check($sformatf("vec%0d.step", idx), {7'd0, bus.step}, {7'd0, v.exp_step});
      @(negedge clk);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rot_seq = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
      bnc_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

      // After reset release: pattern shown, step in cycles 4, 8, 12.
      for (int k = 1; k <= 12; k++) add(2'd0, 8'h00, 1'b0, 8'hBB, (k % DIV) == 0);
      // Static: load 0x0F, hold for 20 ticks.
      add(2'd0, 8'h0F, 1'b1, 8'h0F, 1'b0);
      for (int j = 1; j <= 80; j++) add(2'd0, 8'h00, 1'b0, 8'h0F, (j % DIV) == 0);
      // Blink: load 0xA5, four cycles on, four off, ...
      add(2'd1, 8'hA5, 1'b1, 8'hA5, 1'b0);
      for (int j = 1; j <= 15; j++)
         add(2'd1, 8'h00, 1'b0, (((j / DIV) % 2) == 0) ? 8'hA5 : 8'h00, (j % DIV) == 0);
      // Rotate: load 0x81, walk through the wrap.
      add(2'd2, 8'h81, 1'b1, 8'h81, 1'b0);
      for (int j = 1; j <= 33; j++) add(2'd2, 8'h00, 1'b0, rot_seq[j / DIV], (j % DIV) == 0);
      // Mid-tick switch to bounce: restart at LED0, prescaler from zero.
      add(2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
      for (int j = 1; j <= 63; j++) add(2'd3, 8'h00, 1'b0, bnc_seq[j / DIV], (j % DIV) == 0);
      // Load lands on cnt==3: the tick is lost, bounce restarts at LED0.
      add(2'd3, 8'h3C, 1'b1, 8'h01, 1'b0);
      for (int j = 1; j <= 8; j++) add(2'd3, 8'h00, 1'b0, bnc_seq[j / DIV], (j % DIV) == 0);
      // Static view confirms the collided load still captured the pattern.
      add(2'd0, 8'h00, 1'b0, 8'h3C, 1'b0);
      // Load held high in rotate: display frozen, no steps.
      for (int j = 0; j < 10; j++) add(2'd2, 8'hC3, 1'b1, 8'hC3, 1'b0);
      for (int j = 1; j <= 4; j++) add(2'd2, 8'h00, 1'b0, (j < DIV) ? 8'hC3 : 8'h87, (j % DIV) == 0);
      // All-zero pattern in rotate stays dark.
      add(2'd2, 8'h00, 1'b1, 8'h00, 1'b0);
      for (int j = 1; j <= 8; j++) add(2'd2, 8'h00, 1'b0, 8'h00, (j % DIV) == 0);

      // Asynchronous reset asserted mid-cycle, checked before any edge.
      rst_n       = 1'b1;
      bus.mode    = 2'd0;
      bus.pattern = 8'h00;
      bus.load    = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("reset.led", bus.led, 8'hBB);
      check("reset.step", {7'd0, bus.step}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Reset during rotate: immediate return to the power-up pattern.
      bus.mode    = 2'd2;
      bus.pattern = 8'h81;
      bus.load    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.load = 1'b0;
      for (int j = 1; j <= 5; j++) @(negedge clk);
      #1;
      check("rot_before_rst.led", bus.led, 8'h03);
      bus.mode = 2'd0;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst.led", bus.led, 8'hBB);
      check("mid_rst.step", {7'd0, bus.step}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst%0d.led", k), bus.led, 8'hBB);
         check($sformatf("post_rst%0d.step", k), {7'd0, bus.step}, {7'd0, (k % DIV) == 0});
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_led_pattern_gen
